// File: rtl/nios_led_blink_sequencer.sv
// Avalon-MM LED blink sequencer: steps a 4-entry 2-bit pattern table and writes
// each entry to the LED PIO data register, one write per programmable tick.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | master idle, waiting for enable
// WRITE | PIO write in flight, held until m_waitrequest drops
// COUNT | tick counter running down to the next write
module nios_led_blink_sequencer #(
    parameter int unsigned          PERIOD_W        = 24,
    parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD  = 24'd5000000,
    parameter logic [7:0]           DEFAULT_PATTERN = 8'hE4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                enable_q, enable_d;
    logic                oneshot_q, oneshot_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [7:0]          pattern_q, pattern_d;
    logic [1:0]          step_q, step_d;
    logic [1:0]          last_q, last_d;
    logic [PERIOD_W-1:0] counter_q, counter_d;
    logic [1:0]          data_q, data_d;

    logic                cfg_wr;
    logic [1:0]          cur_pat;
    logic [PERIOD_W-1:0] reload;
    logic                unused_wdata;

    assign cfg_wr       = s_chipselect && !s_write_n;
    assign cur_pat      = pattern_q[{step_q, 1'b0} +: 2];
    assign reload       = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
    assign unused_wdata = ^s_writedata[31:PERIOD_W];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            enable_q  <= 1'b0;
            oneshot_q <= 1'b0;
            period_q  <= DEFAULT_PERIOD;
            pattern_q <= DEFAULT_PATTERN;
            step_q    <= 2'd0;
            last_q    <= 2'd0;
            counter_q <= '0;
            data_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            oneshot_q <= oneshot_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            step_q    <= step_d;
            last_q    <= last_d;
            counter_q <= counter_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        enable_d  = enable_q;
        oneshot_d = oneshot_q;
        period_d  = period_q;
        pattern_d = pattern_q;
        step_d    = step_q;
        last_d    = last_q;
        counter_d = counter_q;
        data_d    = data_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_q) begin
                    state_d = ST_WRITE;
                    data_d  = cur_pat;
                end
            end
            ST_WRITE: begin
                if (!m_waitrequest) begin
                    last_d    = data_q;
                    step_d    = step_q + 2'd1;
                    counter_d = reload;
                    if (oneshot_q && step_q == 2'd3) begin
                        enable_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (!enable_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (!enable_q) begin
                    state_d = ST_IDLE;
                end else if (counter_q == '0) begin
                    state_d = ST_WRITE;
                    data_d  = cur_pat;
                end else begin
                    counter_d = counter_q - PERIOD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU config write comes last so it overrides the oneshot enable clear.
        if (cfg_wr) begin
            case (s_address)
                2'd0: begin
                    enable_d  = s_writedata[0];
                    oneshot_d = s_writedata[1];
                end
                2'd1:    period_d  = s_writedata[PERIOD_W-1:0];
                2'd2:    pattern_d = s_writedata[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            2'd0:    s_readdata[2:0] = {state_q != ST_IDLE, oneshot_q, enable_q};
            2'd1:    s_readdata[PERIOD_W-1:0] = period_q;
            2'd2:    s_readdata[7:0] = pattern_q;
            default: s_readdata[3:0] = {last_q, step_q};
        endcase
    end

    assign m_address    = 2'd0;
    assign m_chipselect = (state_q == ST_WRITE);
    assign m_write_n    = (state_q != ST_WRITE);
    assign m_writedata  = (state_q == ST_WRITE) ? {30'd0, data_q} : 32'd0;

endmodule

// File: tb/tb_nios_led_blink_sequencer.sv
// Directed bench for nios_led_blink_sequencer: config register access, free-run
// sequencing, stalls, oneshot, disable and period-zero behaviour.
module tb_nios_led_blink_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  s_address = 2'd0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = 32'd0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int          starts[$];
    logic [31:0] acc[$];
    logic        prev_act = 1'b0;

    nios_led_blink_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record write start cycles and accepted write data, away from the edge.
    always @(negedge clk) begin
        logic act;
        act = m_chipselect && !m_write_n;
        if (act && !prev_act) starts.push_back(cyc);
        if (act && !m_waitrequest) acc.push_back(m_writedata);
        prev_act = act;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic act_now();
        return m_chipselect && !m_write_n;
    endfunction

    function automatic logic [31:0] pat2(input logic [7:0] p, input int i);
        logic [7:0] t;
        t = p >> (2 * i);
        return {30'd0, t[1:0]};
    endfunction

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        starts.delete();
        acc.delete();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        s_address = a;
        s_writedata = d;
        s_chipselect = 1'b1;
        s_write_n = 1'b0;
        step_cyc();
        s_chipselect = 1'b0;
        s_write_n = 1'b1;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
    endtask

    task automatic wait_act(input string tag, input int max);
        int n = 0;
        while (!act_now() && n < max) begin
            step_cyc();
            n++;
        end
        chk(tag, {31'd0, act_now()}, 32'd1);
    endtask

    task automatic wait_noact(input string tag, input int max);
        int n = 0;
        while (act_now() && n < max) begin
            step_cyc();
            n++;
        end
        chk(tag, {31'd0, act_now()}, 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int max);
        logic [31:0] r;
        int n = 0;
        cfg_read(2'd0, r);
        while (r[2] && n < max) begin
            step_cyc();
            cfg_read(2'd0, r);
            n++;
        end
        chk(tag, {31'd0, r[2]}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [35:0] snap;
        int n;

        // Reset state
        do_reset();
        step_cyc();
        chk("rst_cs", {31'd0, m_chipselect}, 32'd0);
        chk("rst_wn", {31'd0, m_write_n}, 32'd1);
        chk("rst_wdata", m_writedata, 32'd0);
        chk("rst_addr", {30'd0, m_address}, 32'd0);
        cfg_read(2'd0, r); chk("rst_ctrl", r, 32'd0);
        cfg_read(2'd1, r); chk("rst_period", r, 32'd5000000);
        cfg_read(2'd2, r); chk("rst_pattern", r, 32'h0000_00E4);
        cfg_read(2'd3, r); chk("rst_status", r, 32'd0);

        // Free run, period 3, pattern 0x1B
        do_reset();
        cfg_write(2'd1, 32'd3);
        cfg_write(2'd2, 32'h1B);
        cfg_read(2'd2, r); chk("pattern_rb", r, 32'h1B);
        cfg_write(2'd0, 32'd1);
        n = 0;
        while (starts.size() < 5 && n < 80) begin step_cyc(); n++; end
        chk("free_nstarts", (starts.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        if (starts.size() >= 5) begin
            for (int i = 0; i < 4; i++) chk($sformatf("free_gap%0d", i), starts[i+1] - starts[i], 32'd4);
        end
        cfg_write(2'd0, 32'd0);
        wait_idle("free_idle", 20);
        for (int i = 0; i < acc.size() && i < 5; i++) chk($sformatf("free_data%0d", i), acc[i], pat2(8'h1B, i % 4));
        cfg_read(2'd3, r);
        if (acc.size() > 0)
            chk("free_status", r, {28'd0, pat2(8'h1B, (acc.size() - 1) % 4) & 32'd3, 2'b00} | (acc.size() % 4));

        // Stall on the second write
        do_reset();
        cfg_write(2'd1, 32'd3);
        cfg_write(2'd2, 32'h1B);
        cfg_write(2'd0, 32'd1);
        wait_act("stall_w1", 20);
        chk("stall_w1_data", m_writedata, 32'd3);
        wait_noact("stall_w1_end", 5);
        wait_act("stall_w2", 10);
        m_waitrequest = 1'b1;
        snap = {m_chipselect, m_write_n, m_address, m_writedata};
        chk("stall_w2_data", m_writedata, 32'd2);
        for (int i = 1; i <= 4; i++) begin
            step_cyc();
            chk($sformatf("stall_hold%0d", i), {m_chipselect, m_write_n, m_address, m_writedata} == snap, 1);
            if (i == 2) begin cfg_read(2'd3, r); chk("stall_status", r, 32'd13); end
        end
        step_cyc();
        m_waitrequest = 1'b0;
        chk("stall_hold5", {m_chipselect, m_write_n, m_address, m_writedata} == snap, 1);
        for (int i = 0; i < 3; i++) begin
            step_cyc();
            chk($sformatf("stall_count%0d", i), {31'd0, m_chipselect}, 32'd0);
        end
        step_cyc();
        chk("stall_w3", {31'd0, act_now()}, 32'd1);
        chk("stall_w3_data", m_writedata, 32'd1);

        // Oneshot, period 1, default pattern
        do_reset();
        cfg_write(2'd1, 32'd1);
        cfg_write(2'd0, 32'd3);
        wait_act("os_start", 10);
        wait_idle("os_idle", 60);
        repeat (10) step_cyc();
        chk("os_nwrites", acc.size(), 32'd4);
        for (int i = 0; i < acc.size() && i < 4; i++) chk($sformatf("os_data%0d", i), acc[i], i);
        cfg_read(2'd0, r); chk("os_ctrl", r, 32'd2);
        cfg_read(2'd3, r); chk("os_status", r, 32'd12);

        // Disable during a stalled WRITE, then during COUNT
        do_reset();
        cfg_write(2'd1, 32'd3);
        m_waitrequest = 1'b1;
        cfg_write(2'd0, 32'd1);
        wait_act("dis_w_start", 10);
        cfg_write(2'd0, 32'd0);
        chk("dis_w_hold1", {31'd0, act_now()}, 32'd1);
        step_cyc();
        chk("dis_w_hold2", {31'd0, act_now()}, 32'd1);
        step_cyc();
        m_waitrequest = 1'b0;
        chk("dis_w_hold3", {31'd0, act_now()}, 32'd1);
        step_cyc();
        chk("dis_w_done", {31'd0, act_now()}, 32'd0);
        cfg_read(2'd0, r); chk("dis_w_ctrl", r, 32'd0);
        repeat (10) step_cyc();
        chk("dis_w_nwrites", acc.size(), 32'd1);
        cfg_read(2'd3, r); chk("dis_w_status", r, 32'd1);
        cfg_write(2'd0, 32'd1);
        wait_act("dis_c_start", 10);
        chk("dis_c_data", m_writedata, 32'd1);
        step_cyc();
        cfg_read(2'd0, r); chk("dis_c_busy", r, 32'd5);
        cfg_write(2'd0, 32'd0);
        cfg_read(2'd0, r); chk("dis_c_busy2", r, 32'd4);
        step_cyc();
        cfg_read(2'd0, r); chk("dis_c_idle", r, 32'd0);
        repeat (10) step_cyc();
        chk("dis_c_nwrites", acc.size(), 32'd2);

        // Period zero behaves as period one, then reset mid-WRITE
        do_reset();
        cfg_write(2'd1, 32'd0);
        cfg_write(2'd0, 32'd1);
        n = 0;
        while (starts.size() < 4 && n < 40) begin step_cyc(); n++; end
        chk("p0_nstarts", (starts.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        if (starts.size() >= 4) begin
            for (int i = 0; i < 3; i++) chk($sformatf("p0_gap%0d", i), starts[i+1] - starts[i], 32'd2);
        end
        wait_act("p0_act", 5);
        m_waitrequest = 1'b1;
        reset_n = 1'b0;
        step_cyc();
        chk("mrst_cs", {31'd0, m_chipselect}, 32'd0);
        chk("mrst_wn", {31'd0, m_write_n}, 32'd1);
        chk("mrst_wdata", m_writedata, 32'd0);
        cfg_read(2'd0, r); chk("mrst_ctrl", r, 32'd0);
        cfg_read(2'd1, r); chk("mrst_period", r, 32'd5000000);
        cfg_read(2'd2, r); chk("mrst_pattern", r, 32'h0000_00E4);
        cfg_read(2'd3, r); chk("mrst_status", r, 32'd0);
        reset_n = 1'b1;
        m_waitrequest = 1'b0;
        repeat (2) step_cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
